// File: rtl/viterbi_pkg.sv
// Shared code parameters for the 2-bit/8-state Viterbi link (encoder and decoder).
package viterbi_pkg;
    localparam int K     = 4;
    localparam int SYM_W = 2;
    localparam logic [K-1:0] G0 = 4'b1101;
    localparam logic [K-1:0] G1 = 4'b1111;

    typedef enum logic {DATA, TAIL} enc_state_t;
    typedef logic [SYM_W-1:0] sym_t;

    function automatic logic parity(input logic [K-1:0] w, input logic [K-1:0] g);
        return ^(w & g);
    endfunction
endpackage

// File: rtl/conv_enc_core.sv
// Encoder memory and parity: window = {bit, s}, s[K-2] is the most recent previous bit.
module conv_enc_core
    import viterbi_pkg::*;
#(
    parameter logic [K-1:0] P_G0 = G0,
    parameter logic [K-1:0] P_G1 = G1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_bit,
    input  logic i_load,
    output sym_t o_sym
);
    logic [K-2:0] r_s;
    logic [K-1:0] w_win;

    assign w_win = {i_bit, r_s};
    assign o_sym = {parity(w_win, P_G0), parity(w_win, P_G1)};

    always_ff @(posedge clk) begin
        if (!rst)
            r_s <= '0;
        else if (i_load)
            r_s <= w_win[K-1:1];
    end
endmodule

// File: rtl/conv_encoder_framed.sv
// Rate-1/2 K=4 convolutional encoder; each frame is closed with K-1 zero tail bits.
module conv_encoder_framed
    import viterbi_pkg::*;
#(
    parameter int           FRAME_LEN = 8,
    parameter logic [K-1:0] P_G0      = G0,
    parameter logic [K-1:0] P_G1      = G1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_bit_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    output sym_t        sym_o,
    output logic        sym_valid_o,
    input  logic        sym_ready_i,
    output logic        frame_start_o,
    output logic        frame_end_o,
    output logic [15:0] word_ct_o
);
    enc_state_t  r_state;
    logic [15:0] r_bit_ct;
    logic [1:0]  r_tail_ct;
    logic        w_slot_free;
    logic        w_in_data;
    logic        w_load;
    logic        w_bit;
    sym_t        w_sym;

    assign w_slot_free = !sym_valid_o || sym_ready_i;
    assign w_in_data   = (r_state == DATA);
    assign in_ready_o  = w_in_data && w_slot_free;
    // Tail bits are implicit zeros, loaded whenever the output slot frees up.
    assign w_load      = w_in_data ? (in_valid_i && w_slot_free) : w_slot_free;
    assign w_bit       = w_in_data && in_bit_i;

    conv_enc_core #(.P_G0(P_G0), .P_G1(P_G1)) u_core (
        .clk    (clk),
        .rst    (rst),
        .i_bit  (w_bit),
        .i_load (w_load),
        .o_sym  (w_sym)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= DATA;
            r_bit_ct      <= '0;
            r_tail_ct     <= '0;
            sym_o         <= '0;
            sym_valid_o   <= 1'b0;
            frame_start_o <= 1'b0;
            frame_end_o   <= 1'b0;
            word_ct_o     <= '0;
        end else begin
            if (w_load) begin
                sym_o         <= w_sym;
                sym_valid_o   <= 1'b1;
                frame_start_o <= w_in_data && (r_bit_ct == 16'd0);
                frame_end_o   <= !w_in_data && (r_tail_ct == 2'(K-2));
            end else if (sym_ready_i) begin
                sym_valid_o   <= 1'b0;
            end

            if (w_load) begin
                if (w_in_data) begin
                    if (r_bit_ct == 16'(FRAME_LEN-1)) begin
                        r_bit_ct <= '0;
                        r_state  <= TAIL;
                    end else begin
                        r_bit_ct <= r_bit_ct + 16'd1;
                    end
                end else begin
                    if (r_tail_ct == 2'(K-2)) begin
                        r_tail_ct <= '0;
                        r_state   <= DATA;
                        word_ct_o <= word_ct_o + 16'd1;
                    end else begin
                        r_tail_ct <= r_tail_ct + 2'd1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_conv_encoder_framed.sv
// Bench for conv_encoder_framed: vector tables, corner sequences and a random scoreboard.
module tb_conv_encoder_framed;
    import viterbi_pkg::*;
    localparam int FLEN = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic in_bit = 1'b0, in_valid = 1'b0, sym_ready = 1'b1;
    logic in_ready, sym_valid, fs, fe;
    sym_t sym;
    logic [15:0] word_ct;

    logic in_bit1 = 1'b0, in_valid1 = 1'b0, sym_ready1 = 1'b1;
    logic in_ready1, sym_valid1, fs1, fe1;
    sym_t sym1;
    logic [15:0] word_ct1;

    conv_encoder_framed #(.FRAME_LEN(FLEN)) dut (
        .clk(clk), .rst(rst), .in_bit_i(in_bit), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .sym_o(sym), .sym_valid_o(sym_valid), .sym_ready_i(sym_ready),
        .frame_start_o(fs), .frame_end_o(fe), .word_ct_o(word_ct));

    conv_encoder_framed #(.FRAME_LEN(1)) dut1 (
        .clk(clk), .rst(rst), .in_bit_i(in_bit1), .in_valid_i(in_valid1), .in_ready_o(in_ready1),
        .sym_o(sym1), .sym_valid_o(sym_valid1), .sym_ready_i(sym_ready1),
        .frame_start_o(fs1), .frame_end_o(fe1), .word_ct_o(word_ct1));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: convolution over the current frame's accepted bits, zero padded.
    typedef struct { logic [1:0] s; bit st; bit en; } exp_t;
    exp_t expq[$];
    bit   cur[$];
    int   exp_frames = 0;
    int   acc_ct = 0;
    bit   sb_en = 1'b0;
    bit   stall_prev = 1'b0;
    logic [1:0] h_s;
    logic h_st, h_en;
    exp_t e_hd;

    function automatic bit ub(int k);
        if (k < 0 || k >= cur.size()) return 1'b0;
        return cur[k];
    endfunction

    function automatic logic [1:0] code(int n);
        bit u0, u1, u2, u3;
        u0 = ub(n); u1 = ub(n-1); u2 = ub(n-2); u3 = ub(n-3);
        return {u0 ^ u1 ^ u3, u0 ^ u1 ^ u2 ^ u3};
    endfunction

    always @(negedge clk) begin
        if (rst && sb_en) begin
            if (stall_prev) begin
                chk("hold_sym", sym, h_s);
                chk("hold_flags", {fs, fe}, {h_st, h_en});
                chk("hold_valid", sym_valid, 1);
            end
            if (sym_valid && !sym_ready) chk("bp_in_ready", in_ready, 0);
            stall_prev = sym_valid && !sym_ready;
            h_s = sym; h_st = fs; h_en = fe;
            if (sym_valid && sym_ready) begin
                if (expq.size() == 0) chk("sb_extra_sym", 1, 0);
                else begin
                    e_hd = expq.pop_front();
                    chk("sb_sym", sym, e_hd.s);
                    chk("sb_flags", {fs, fe}, {e_hd.st, e_hd.en});
                end
            end
            if (in_valid && in_ready) begin
                cur.push_back(in_bit);
                acc_ct++;
                expq.push_back('{code(cur.size()-1), cur.size() == 1, 1'b0});
                if (cur.size() == FLEN) begin
                    for (int t = 0; t < 3; t++) expq.push_back('{code(FLEN+t), 1'b0, t == 2});
                    cur.delete();
                    exp_frames++;
                end
            end
        end
    end

    typedef struct { bit sel; bit b; bit v; bit rdy; logic [1:0] s; bit st; bit en; } vec_t;
    vec_t tbl[$];

    task automatic add(input bit sel, input bit b, input bit v, input bit rdy,
                       input logic [1:0] s, input bit st, input bit en);
        vec_t r;
        r.sel = sel; r.b = b; r.v = v; r.rdy = rdy; r.s = s; r.st = st; r.en = en;
        tbl.push_back(r);
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (tbl[i].sel) begin in_bit1 = tbl[i].b; in_valid1 = tbl[i].v; end
            else begin in_bit = tbl[i].b; in_valid = tbl[i].v; end
            @(negedge clk);
            chk("tbl_in_ready", tbl[i].sel ? in_ready1 : in_ready, tbl[i].rdy);
            @(posedge clk); #1;
            chk("tbl_sym", tbl[i].sel ? sym1 : sym, tbl[i].s);
            chk("tbl_valid", tbl[i].sel ? sym_valid1 : sym_valid, 1);
            chk("tbl_flags", tbl[i].sel ? {fs1, fe1} : {fs, fe}, {tbl[i].st, tbl[i].en});
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_sym"}, sym, 0);
        chk({nm, "_valid"}, sym_valid, 0);
        chk({nm, "_flags"}, {fs, fe}, 0);
        chk({nm, "_word_ct"}, word_ct, 0);
    endtask

    logic [1:0] imp_s [0:10];
    logic [1:0] one_s [0:10];
    logic [1:0] f1_s  [0:3];
    bit   mid_bits [0:3];
    int   cyc;

    initial begin
        imp_s = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        one_s = '{2'b11, 2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b11};
        f1_s  = '{2'b11, 2'b11, 2'b01, 2'b11};
        mid_bits = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 11; i++) add(0, i == 0, i < 8, i < 8, imp_s[i], i == 0, i == 10);
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 11; i++) add(0, 1'b1, 1'b1, i < 8, one_s[i], i == 0, i == 10);
        for (int i = 0; i < 4; i++) add(1, 1'b1, 1'b1, i == 0, f1_s[i], i == 0, i == 3);

        // Reset values, then reset mid-frame after 4 accepted bits.
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        chk_reset_vals("rst");
        @(negedge clk); chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            in_bit = mid_bits[i]; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        chk("mid_valid_before", sym_valid, 1);
        in_valid = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        chk_reset_vals("midrst");
        rst = 1'b1;
        @(negedge clk); chk("midrst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Impulse, then two back-to-back all-ones frames, scoreboard running alongside.
        sb_en = 1'b1;
        run_rows(0, 10);
        chk("imp_word_ct", word_ct, 1);
        run_rows(11, 21);
        chk("ones1_word_ct", word_ct, 2);
        run_rows(22, 32);
        chk("ones2_word_ct", word_ct, 3);
        in_valid = 1'b0;

        // Backpressure mid-frame: 5 stalled cycles with the source still offering bits.
        for (int i = 0; i < 3; i++) begin
            in_bit = 1'($urandom); in_valid = 1'b1;
            @(posedge clk); #1;
        end
        sym_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_bit = 1'($urandom);
            @(negedge clk); chk("stall_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        sym_ready = 1'b1;

        // Random traffic until at least 256 more bits and a closed frame.
        acc_ct = 0; cyc = 0;
        while ((acc_ct < 256 || cur.size() != 0) && cyc < 5000) begin
            in_bit = 1'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            sym_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            cyc++;
        end
        chk("rand_no_timeout", cyc < 5000, 1);
        in_valid = 1'b0; sym_ready = 1'b1;
        cyc = 0;
        while (expq.size() != 0 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("drain_empty", expq.size(), 0);
        chk("rand_word_ct", word_ct, exp_frames[15:0]);
        sb_en = 1'b0;

        // FRAME_LEN = 1: the single bit goes straight to tail.
        run_rows(33, 36);
        in_valid1 = 1'b0;
        chk("f1_word_ct", word_ct1, 1);
        @(negedge clk); chk("f1_in_ready_after", in_ready1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
